mix_chain_sequencer: RTL and testbench

- Timed fluid-dispense controller for a parametrised mixer/serpentine chain of N inlets feeding cascaded diffusion mixers.
- Doses each inlet valve in turn for a programmed time, then waits a per-inlet serpentine transit time.
- After all inlets, enables the mixer for a hold time, then drains through the outlet valve until the outlet sensor trips.
- Sits between the host control register bank and the chip's valve/pump drivers; one instance per mixing chain.

---
 rtl/mfda_seq_pkg.sv | 31 +++
 rtl/mix_chain_sequencer_phase_timer.sv | 45 ++++
 rtl/mix_chain_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mix_chain_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfda_seq_pkg.sv
// ---------------------------------------------------------------------------
// mfda_seq_pkg
// Shared definitions for the mixing-chain sequencer:
//   - state_t       : sequencer state encoding
//   - DEFAULT_CNT_W : default width of tick counters / programmed durations
//   - idx_width()   : width of the inlet index, clog2(n) with a floor of 1
// ---------------------------------------------------------------------------
package mfda_seq_pkg;

   localparam int DEFAULT_CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DOSE    = 3'd1,
      TRANSIT = 3'd2,
      MIX     = 3'd3,
      DRAIN   = 3'd4,
      FLUSH   = 3'd5,
      DONE    = 3'd6
   } state_t;

   // Inlet index width; a single inlet still needs a 1-bit index.
   function automatic int idx_width(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/mix_chain_sequencer_phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
// Loadable down-counter shared by every timed phase of the sequencer.
// A load of duration d makes the counter read d-1 on the first cycle of the
// phase; the phase is over on the cycle the counter reads zero, so a phase
// lasts exactly d cycles. A duration of 0 loads 0 rather than wrapping.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   load     in   load (duration-1) on this edge
//   duration in   CNT_W  phase length in cycles
//   expired  out  counter currently reads zero
// ---------------------------------------------------------------------------
module phase_timer #(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] duration,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_r;

   // Down-counter: load on phase entry, otherwise count down and hold at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (load) begin
         if (duration == {CNT_W{1'b0}}) begin
            cnt_r <= {CNT_W{1'b0}};
         end else begin
            cnt_r <= duration - {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else if (cnt_r != {CNT_W{1'b0}}) begin
         cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expired = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mix_chain_sequencer.sv
// ---------------------------------------------------------------------------
// mix_chain_sequencer
// Timed dispense controller for one mixer/serpentine chain: doses each inlet
// in turn, waits its serpentine transit time, runs the mixer, then drains
// through the outlet until the outlet sensor trips.
// Optional build macro MIX_FLUSH_EN adds a FLUSH phase (outlet + flush valve
// open for FLUSH_TICKS cycles) between DRAIN and DONE, and port flush_valve_o.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start_i / ready_o  run request, accepted only while ready_o=1
//   abort_i            synchronous abort of a running sequence
//   dose_ticks_i       per-inlet dose cycles, slice i = inlet i
//   transit_ticks_i    per-inlet post-dose wait cycles
//   mix_ticks_i        mixer-enable cycles
//   out_sense_i        outlet fluid detected (already synchronised)
//   valve_o            inlet valves, one-hot or zero
//   mixer_en_o, out_valve_o, busy_o, done_o, aborted_o
//   flush_valve_o      (MIX_FLUSH_EN only) flush valve
// ---------------------------------------------------------------------------
module mix_chain_sequencer
   import mfda_seq_pkg::*;
#(
   parameter int N_INLETS    = 3,
   parameter int CNT_W       = DEFAULT_CNT_W,
   parameter int FLUSH_TICKS = 64
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_i,
   output logic                      ready_o,
   input  logic                      abort_i,
   input  logic [N_INLETS*CNT_W-1:0] dose_ticks_i,
   input  logic [N_INLETS*CNT_W-1:0] transit_ticks_i,
   input  logic [CNT_W-1:0]          mix_ticks_i,
   input  logic                      out_sense_i,
   output logic [N_INLETS-1:0]       valve_o,
   output logic                      mixer_en_o,
   output logic                      out_valve_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      aborted_o
`ifdef MIX_FLUSH_EN
   ,output logic                     flush_valve_o
`endif
);

   // The run is a linear list of positions: DOSE(0), TRANSIT(0), ...,
   // DOSE(N-1), TRANSIT(N-1), MIX, DRAIN. Zero-length positions are skipped
   // by searching forward for the next non-zero one.
   localparam int IDX_W     = idx_width(N_INLETS);
   localparam int NPOS      = 2 * N_INLETS + 2;
   localparam int MIX_POS   = 2 * N_INLETS;
   localparam int DRAIN_POS = 2 * N_INLETS + 1;
   localparam int POS_W     = $clog2(NPOS + 1);
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_TICKS);

   state_t                    state_r, nxt_state_s, pos_state_s;
   logic [IDX_W-1:0]          idx_r, nxt_idx_s, pos_idx_s;
   logic [N_INLETS*CNT_W-1:0] dose_r, transit_r, src_dose_s, src_transit_s;
   logic [CNT_W-1:0]          mix_r, src_mix_s, next_dur_s, load_dur_s;
   logic [CNT_W-1:0]          pos_dur_s [NPOS];
   logic [POS_W-1:0]          cur_pos_s, search_from_s, next_pos_s;
   logic                      found_s, accept_s, aborting_s, load_s, expired_s;

   logic [N_INLETS-1:0]       valve_r;
   logic                      mixer_r, out_valve_r, busy_r, done_r, aborted_r, ready_r;

   assign accept_s = ready_r & start_i & (state_r == IDLE);

   // On the accepting cycle the durations come straight from the inputs,
   // since the latch only captures them on that same edge.
   assign src_dose_s    = accept_s ? dose_ticks_i    : dose_r;
   assign src_transit_s = accept_s ? transit_ticks_i : transit_r;
   assign src_mix_s     = accept_s ? mix_ticks_i     : mix_r;

   // Programming latch, captured once per accepted run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dose_r    <= {(N_INLETS*CNT_W){1'b0}};
         transit_r <= {(N_INLETS*CNT_W){1'b0}};
         mix_r     <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         dose_r    <= dose_ticks_i;
         transit_r <= transit_ticks_i;
         mix_r     <= mix_ticks_i;
      end else begin
         dose_r    <= dose_r;
         transit_r <= transit_r;
         mix_r     <= mix_r;
      end
   end

   // Position of the current state in the run list.
   always_comb begin
      cur_pos_s = POS_W'(DRAIN_POS);
      case (state_r)
         DOSE:    cur_pos_s = POS_W'({idx_r, 1'b0});
         TRANSIT: cur_pos_s = POS_W'({idx_r, 1'b1});
         MIX:     cur_pos_s = POS_W'(MIX_POS);
         default: cur_pos_s = POS_W'(DRAIN_POS);
      endcase
   end

   assign search_from_s = accept_s ? {POS_W{1'b0}} : (cur_pos_s + POS_W'(1));

   // Duration of every position; DRAIN counts as non-zero so the search ends there.
   always_comb begin
      for (int p = 0; p < NPOS; p++) begin
         if (p < MIX_POS) begin
            if ((p % 2) == 0) begin
               pos_dur_s[p] = src_dose_s[(p/2)*CNT_W +: CNT_W];
            end else begin
               pos_dur_s[p] = src_transit_s[(p/2)*CNT_W +: CNT_W];
            end
         end else if (p == MIX_POS) begin
            pos_dur_s[p] = src_mix_s;
         end else begin
            pos_dur_s[p] = {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // First non-zero position at or after search_from_s.
   always_comb begin
      found_s    = 1'b0;
      next_pos_s = POS_W'(DRAIN_POS);
      next_dur_s = {CNT_W{1'b0}};
      for (int p = 0; p < NPOS; p++) begin
         if (!found_s && (POS_W'(p) >= search_from_s) && (pos_dur_s[p] != {CNT_W{1'b0}})) begin
            found_s    = 1'b1;
            next_pos_s = POS_W'(p);
            next_dur_s = pos_dur_s[p];
         end else begin
            found_s    = found_s;
         end
      end
   end

   // Map the found position back onto state + inlet index.
   always_comb begin
      pos_state_s = DRAIN;
      pos_idx_s   = {IDX_W{1'b0}};
      if (next_pos_s < POS_W'(MIX_POS)) begin
         pos_state_s = next_pos_s[0] ? TRANSIT : DOSE;
         pos_idx_s   = IDX_W'(next_pos_s >> 1);
      end else if (next_pos_s == POS_W'(MIX_POS)) begin
         pos_state_s = MIX;
      end else begin
         pos_state_s = DRAIN;
      end
   end

   // Next-state logic; abort overrides any running state.
   always_comb begin
      nxt_state_s = state_r;
      nxt_idx_s   = idx_r;
      aborting_s  = 1'b0;
      load_s      = 1'b0;
      load_dur_s  = next_dur_s;
      if ((state_r != IDLE) && abort_i) begin
         nxt_state_s = IDLE;
         nxt_idx_s   = {IDX_W{1'b0}};
         aborting_s  = 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  nxt_state_s = pos_state_s;
                  nxt_idx_s   = pos_idx_s;
                  load_s      = 1'b1;
               end else begin
                  nxt_state_s = IDLE;
               end
            end
            DOSE, TRANSIT, MIX: begin
               if (expired_s) begin
                  nxt_state_s = pos_state_s;
                  nxt_idx_s   = pos_idx_s;
                  load_s      = 1'b1;
               end else begin
                  nxt_state_s = state_r;
               end
            end
            DRAIN: begin
               load_dur_s = FLUSH_LOAD;
               if (out_sense_i) begin
`ifdef MIX_FLUSH_EN
                  nxt_state_s = FLUSH;
                  load_s      = 1'b1;
`else
                  nxt_state_s = DONE;
`endif
               end else begin
                  nxt_state_s = DRAIN;
               end
            end
            FLUSH: begin
               if (expired_s) begin
                  nxt_state_s = DONE;
               end else begin
                  nxt_state_s = FLUSH;
               end
            end
            DONE:    nxt_state_s = IDLE;
            default: nxt_state_s = IDLE;
         endcase
      end
   end

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_s),
      .duration (load_dur_s),
      .expired  (expired_s)
   );

   // FSM state register with outputs decoded from the next state, so every
   // output lines up with the state it belongs to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         idx_r       <= {IDX_W{1'b0}};
         valve_r     <= {N_INLETS{1'b0}};
         mixer_r     <= 1'b0;
         out_valve_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         aborted_r   <= 1'b0;
         ready_r     <= 1'b1;
      end else begin
         state_r     <= nxt_state_s;
         idx_r       <= nxt_idx_s;
         valve_r     <= (nxt_state_s == DOSE) ? (N_INLETS'(1) << nxt_idx_s) : {N_INLETS{1'b0}};
         mixer_r     <= (nxt_state_s == MIX);
         out_valve_r <= (nxt_state_s == DRAIN) || (nxt_state_s == FLUSH);
         busy_r      <= (nxt_state_s != IDLE);
         done_r      <= (nxt_state_s == DONE);
         aborted_r   <= aborting_s;
         // The abort-pulse cycle is spent in IDLE but not yet ready.
         ready_r     <= (nxt_state_s == IDLE) && !aborting_s;
      end
   end

   assign valve_o     = valve_r;
   assign mixer_en_o  = mixer_r;
   assign out_valve_o = out_valve_r;
   assign busy_o      = busy_r;
   assign done_o      = done_r;
   assign aborted_o   = aborted_r;
   assign ready_o     = ready_r;

`ifdef MIX_FLUSH_EN
   logic flush_r;

   // Flush valve follows the FLUSH state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_r <= 1'b0;
      end else begin
         flush_r <= (nxt_state_s == FLUSH);
      end
   end

   assign flush_valve_o = flush_r;
`endif

endmodule

// File: tb/tb_mix_chain_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mix_chain_sequencer
// Scoreboard bench: each test pushes per-cycle stimulus and expected output
// words into a queue; run_steps drives and compares cycle by cycle.
// Word layout: {ready, busy, valve[N-1:0], mixer, out_valve, flush, done, aborted}
// ---------------------------------------------------------------------------
module tb_mix_chain_sequencer;

   localparam int N  = 3;
   localparam int CW = 16;
   localparam int FT = 64;
   localparam int W  = N + 7;
`ifdef MIX_FLUSH_EN
   localparam int FC = FT;
`else
   localparam int FC = 0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start_i = 1'b0;
   logic            abort_i = 1'b0;
   logic            out_sense_i = 1'b0;
   logic [N*CW-1:0] dose_ticks_i = '0;
   logic [N*CW-1:0] transit_ticks_i = '0;
   logic [CW-1:0]   mix_ticks_i = '0;
   logic            ready_o, mixer_en_o, out_valve_o, busy_o, done_o, aborted_o;
   logic [N-1:0]    valve_o;
   logic            flush_w;

`ifdef MIX_FLUSH_EN
   logic flush_valve_o;
   assign flush_w = flush_valve_o;
`else
   assign flush_w = 1'b0;
`endif

   mix_chain_sequencer #(.N_INLETS(N), .CNT_W(CW), .FLUSH_TICKS(FT)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start_i         (start_i),
      .ready_o         (ready_o),
      .abort_i         (abort_i),
      .dose_ticks_i    (dose_ticks_i),
      .transit_ticks_i (transit_ticks_i),
      .mix_ticks_i     (mix_ticks_i),
      .out_sense_i     (out_sense_i),
      .valve_o         (valve_o),
      .mixer_en_o      (mixer_en_o),
      .out_valve_o     (out_valve_o),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .aborted_o       (aborted_o)
`ifdef MIX_FLUSH_EN
      ,.flush_valve_o  (flush_valve_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] exp;
      bit           sense;
      bit           start;
      bit           abort;
      bit           scramble;
   } step_t;

   step_t sq[$];
   int    checks = 0;
   int    errors = 0;
   int    prog_dose[N];
   int    prog_transit[N];
   int    prog_mix;
   int    cyc;
   int    done_at;
   bit    valve1_seen;

   function automatic logic [W-1:0] mk(input logic rdy, input logic bsy, input logic [N-1:0] v,
                                       input logic mx, input logic ov, input logic fl,
                                       input logic dn, input logic ab);
      return {rdy, bsy, v, mx, ov, fl, dn, ab};
   endfunction

   function automatic logic [W-1:0] obs_word();
      return {ready_o, busy_o, valve_o, mixer_en_o, out_valve_o, flush_w, done_o, aborted_o};
   endfunction

   task automatic push(input logic [W-1:0] e, input bit sense, input bit start, input bit abort, input bit scr);
      step_t s;
      s.exp = e; s.sense = sense; s.start = start; s.abort = abort; s.scramble = scr;
      sq.push_back(s);
   endtask

   task automatic set_prog(input int d0, input int d1, input int d2,
                           input int t0, input int t1, input int t2, input int m);
      prog_dose[0] = d0; prog_dose[1] = d1; prog_dose[2] = d2;
      prog_transit[0] = t0; prog_transit[1] = t1; prog_transit[2] = t2;
      prog_mix = m;
   endtask

   // Expected waveform of one complete run from the accepting cycle to idle.
   task automatic build_run(input int sense_delay, input bit sense_pre, input bit start_abort,
                            input bit scr, input bit busy_pokes);
      logic [N-1:0] oh;
      push(mk(1, 0, '0, 0, 0, 0, 0, 0), sense_pre, 1, start_abort, 0);
      for (int i = 0; i < N; i++) begin
         oh = N'(1) << i;
         for (int k = 0; k < prog_dose[i]; k++)    push(mk(0, 1, oh, 0, 0, 0, 0, 0), sense_pre, 0, 0, scr);
         for (int k = 0; k < prog_transit[i]; k++) push(mk(0, 1, '0, 0, 0, 0, 0, 0), sense_pre, busy_pokes, 0, scr);
      end
      for (int k = 0; k < prog_mix; k++) push(mk(0, 1, '0, 1, 0, 0, 0, 0), sense_pre, busy_pokes, 0, scr);
      for (int j = 0; j <= sense_delay; j++)
         push(mk(0, 1, '0, 0, 1, 0, 0, 0), sense_pre | (j >= sense_delay), 0, 0, 0);
      for (int k = 0; k < FC; k++) push(mk(0, 1, '0, 0, 1, 1, 0, 0), 1, 0, 0, 0);
      push(mk(0, 1, '0, 0, 0, 0, 1, 0), 0, 0, 0, 0);
      push(mk(1, 0, '0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
   endtask

   task automatic run_steps(input string tname);
      step_t        s;
      logic [W-1:0] got;
      cyc = -1;
      done_at = -1;
      valve1_seen = 1'b0;
      while (sq.size() > 0) begin
         s = sq.pop_front();
         start_i = s.start;
         abort_i = s.abort;
         out_sense_i = s.sense;
         for (int i = 0; i < N; i++) begin
            if (s.scramble) begin
               dose_ticks_i[i*CW +: CW]    = CW'($urandom_range(0, 65535));
               transit_ticks_i[i*CW +: CW] = CW'($urandom_range(0, 65535));
            end else begin
               dose_ticks_i[i*CW +: CW]    = CW'(prog_dose[i]);
               transit_ticks_i[i*CW +: CW] = CW'(prog_transit[i]);
            end
         end
         mix_ticks_i = s.scramble ? CW'($urandom_range(0, 65535)) : CW'(prog_mix);
         @(negedge clk);
         cyc++;
         got = obs_word();
         checks++;
         if (got !== s.exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", tname, cyc, got, s.exp);
         end
         if (done_o === 1'b1 && done_at < 0) done_at = cyc;
         if (valve_o[1] === 1'b1) valve1_seen = 1'b1;
         @(posedge clk);
         #1;
      end
      start_i = 1'b0;
      abort_i = 1'b0;
      out_sense_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs_word() !== mk(1, 0, '0, 0, 0, 0, 0, 0)) begin
         errors++;
         $display("FAIL reset_state: got %b expected %b", obs_word(), mk(1, 0, '0, 0, 0, 0, 0, 0));
      end
      rst_n = 1'b1;
      push(mk(1, 0, '0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
      push(mk(1, 0, '0, 0, 0, 0, 0, 0), 0, 0, 1, 0);
      push(mk(1, 0, '0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
      run_steps("reset_idle");
   endtask

   task automatic test_nominal();
      set_prog(4, 2, 3, 5, 1, 2, 6);
      build_run(3, 0, 0, 1, 1);
      run_steps("nominal");
      checks++;
      if (done_at !== 28 + FC) begin
         errors++;
         $display("FAIL nominal_done_cycle: got %0d expected %0d", done_at, 28 + FC);
      end
   endtask

   task automatic test_skip();
      set_prog(4, 0, 3, 5, 0, 2, 6);
      build_run(3, 0, 0, 0, 0);
      run_steps("skip");
      checks++;
      if (done_at !== 25 + FC) begin
         errors++;
         $display("FAIL skip_done_cycle: got %0d expected %0d", done_at, 25 + FC);
      end
      checks++;
      if (valve1_seen !== 1'b0) begin
         errors++;
         $display("FAIL skip_valve1: got %0d expected 0", valve1_seen);
      end
   endtask

   task automatic test_zero_durations();
      set_prog(0, 0, 0, 0, 0, 0, 0);
      build_run(0, 1, 1, 0, 0);
      run_steps("zero");
      checks++;
      if (done_at !== 2 + FC) begin
         errors++;
         $display("FAIL zero_done_cycle: got %0d expected %0d", done_at, 2 + FC);
      end
   endtask

   task automatic test_abort();
      set_prog(2, 5, 1, 1, 1, 1, 2);
      push(mk(1, 0, '0, 0, 0, 0, 0, 0), 0, 1, 0, 0);      // c0 accept
      push(mk(0, 1, 3'b001, 0, 0, 0, 0, 0), 0, 0, 0, 0);  // c1
      push(mk(0, 1, 3'b001, 0, 0, 0, 0, 0), 0, 0, 0, 0);  // c2
      push(mk(0, 1, '0, 0, 0, 0, 0, 0), 0, 0, 0, 0);      // c3 transit0
      push(mk(0, 1, 3'b010, 0, 0, 0, 0, 0), 0, 0, 0, 0);  // c4
      push(mk(0, 1, 3'b010, 0, 0, 0, 0, 0), 0, 0, 0, 0);  // c5
      push(mk(0, 1, 3'b010, 0, 0, 0, 0, 0), 0, 0, 1, 0);  // c6 abort
      push(mk(0, 0, '0, 0, 0, 0, 0, 1), 0, 1, 0, 0);      // c7 pulse, start ignored
      push(mk(1, 0, '0, 0, 0, 0, 0, 0), 0, 1, 0, 0);      // c8 accept
      push(mk(0, 1, 3'b001, 0, 0, 0, 0, 0), 0, 0, 1, 0);  // c9 abort again
      push(mk(0, 0, '0, 0, 0, 0, 0, 1), 0, 0, 0, 0);      // c10
      push(mk(1, 0, '0, 0, 0, 0, 0, 0), 0, 0, 1, 0);      // c11 idle abort ignored
      push(mk(1, 0, '0, 0, 0, 0, 0, 0), 0, 0, 0, 0);      // c12
      run_steps("abort");
      checks++;
      if (done_at !== -1) begin
         errors++;
         $display("FAIL abort_no_done: got %0d expected -1", done_at);
      end
   endtask

   task automatic test_reset_mid_run();
      set_prog(1, 1, 1, 1, 1, 1, 10);
      push(mk(1, 0, '0, 0, 0, 0, 0, 0), 0, 1, 0, 0);
      push(mk(0, 1, 3'b001, 0, 0, 0, 0, 0), 0, 0, 0, 0);
      push(mk(0, 1, '0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
      push(mk(0, 1, 3'b010, 0, 0, 0, 0, 0), 0, 0, 0, 0);
      push(mk(0, 1, '0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
      push(mk(0, 1, 3'b100, 0, 0, 0, 0, 0), 0, 0, 0, 0);
      push(mk(0, 1, '0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) push(mk(0, 1, '0, 1, 0, 0, 0, 0), 0, 0, 0, 0);
      run_steps("pre_reset");
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs_word() !== mk(1, 0, '0, 0, 0, 0, 0, 0)) begin
         errors++;
         $display("FAIL async_reset_mix: got %b expected %b", obs_word(), mk(1, 0, '0, 0, 0, 0, 0, 0));
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) push(mk(1, 0, '0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
      run_steps("post_reset");
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_skip();
      test_zero_durations();
      test_abort();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
